// File: rtl/dsa_simd_pkg.sv
// Shared types and constants for the SIMD bilinear fetch unit.
package dsa_simd_pkg;

  localparam int FRAC_BITS = 8;
  localparam int PIX_W     = 8;

  localparam logic [1:0] N00 = 2'd0;
  localparam logic [1:0] N01 = 2'd1;
  localparam logic [1:0] N10 = 2'd2;
  localparam logic [1:0] N11 = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/dsa_coord_map.sv
// One axis of the output-to-source mapping: Q8.8 scale, edge clamp and fraction.
module dsa_coord_map
  import dsa_simd_pkg::*;
(
  input  logic [16:0] coord,
  input  logic [15:0] scale,
  input  logic [15:0] size,
  output logic [15:0] c0,
  output logic [15:0] c1,
  output logic [7:0]  frac
);

  logic [23:0] coord_ext_s;
  logic [23:0] scale_ext_s;
  logic [23:0] prod_s;
  logic [15:0] int_s;
  logic [15:0] max_s;
  logic        clamp_s;

  // Only bits [23:0] of the product feed the integer and fraction fields.
  always_comb begin
    coord_ext_s = {7'd0, coord};
    scale_ext_s = {8'd0, scale};
    prod_s      = coord_ext_s * scale_ext_s;
    int_s       = prod_s[FRAC_BITS +: 16];
    max_s       = size - 16'd1;
    clamp_s     = (int_s > max_s);
    c0          = clamp_s ? max_s : int_s;
    c1          = (c0 >= max_s) ? max_s : (c0 + 16'd1);
    frac        = clamp_s ? 8'd0 : prod_s[FRAC_BITS-1:0];
  end

endmodule

// File: rtl/dsa_fetch_unit_simd.sv
// Maps one SIMD group of output pixels to source coordinates and reads the
// four bilinear neighbours of every valid lane from source memory.
module dsa_fetch_unit_simd
  import dsa_simd_pkg::*;
#(
  parameter int                    SIMD_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [15:0]              current_x,
  input  logic [15:0]              current_y,
  input  logic [15:0]              img_width_in,
  input  logic [15:0]              img_height_in,
  input  logic [15:0]              img_width_out,
  input  logic [15:0]              scale_x,
  input  logic [15:0]              scale_y,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [7:0]               mem_rd_data,
  output logic                     fetch_done,
  output logic                     busy,
  output logic [SIMD_WIDTH*32-1:0] pix_out,
  output logic [SIMD_WIDTH*8-1:0]  frac_x,
  output logic [7:0]               frac_y,
  output logic [SIMD_WIDTH-1:0]    lane_valid
);

  localparam int LANE_W = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;

  fetch_state_t state_r;
  fetch_state_t state_nx_s;

  logic [15:0] cur_x_r, cur_y_r, w_in_r, h_in_r, w_out_r, scale_x_r, scale_y_r;

  logic [15:0] x0_s [SIMD_WIDTH];
  logic [15:0] x1_s [SIMD_WIDTH];
  logic [7:0]  fx_s [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] lv_s;
  logic [15:0] y0_s, y1_s;
  logic [7:0]  fy_s;

  logic [15:0] x0_r [SIMD_WIDTH];
  logic [15:0] x1_r [SIMD_WIDTH];
  logic [15:0] y0_r, y1_r;

  logic [LANE_W-1:0] rd_lane_r;
  logic [1:0]        rd_idx_r;
  logic              cap_en_r;
  logic [LANE_W-1:0] cap_lane_r;
  logic [1:0]        cap_idx_r;

  logic [SIMD_WIDTH*32-1:0] pix_r;
  logic [SIMD_WIDTH*8-1:0]  frac_x_r;
  logic [7:0]               frac_y_r;
  logic [SIMD_WIDTH-1:0]    lane_valid_r;

  logic [15:0] sel_x0_s, sel_x1_s, rd_x_s, rd_y_s;
  logic        nxt_valid_s;
  logic        last_rd_s;

  for (genvar i = 0; i < SIMD_WIDTH; i++) begin : g_lane
    logic [16:0] xo_s;
    assign xo_s    = {1'b0, cur_x_r} + 17'(i);
    assign lv_s[i] = (xo_s < {1'b0, w_out_r});

    dsa_coord_map u_map_x (
      .coord (xo_s),
      .scale (scale_x_r),
      .size  (w_in_r),
      .c0    (x0_s[i]),
      .c1    (x1_s[i]),
      .frac  (fx_s[i])
    );
  end

  dsa_coord_map u_map_y (
    .coord ({1'b0, cur_y_r}),
    .scale (scale_y_r),
    .size  (h_in_r),
    .c0    (y0_s),
    .c1    (y1_s),
    .frac  (fy_s)
  );

  // Valid lanes form a prefix (xo grows with the lane index), so the group ends
  // at the last neighbour of the lane whose successor is invalid or absent.
  always_comb begin
    sel_x0_s    = 16'd0;
    sel_x1_s    = 16'd0;
    nxt_valid_s = 1'b0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      sel_x0_s    = (rd_lane_r == LANE_W'(i)) ? x0_r[i] : sel_x0_s;
      sel_x1_s    = (rd_lane_r == LANE_W'(i)) ? x1_r[i] : sel_x1_s;
      nxt_valid_s = (i == int'(rd_lane_r) + 1) ? lane_valid_r[i] : nxt_valid_s;
    end
    last_rd_s = (rd_idx_r == N11) && !nxt_valid_s;
  end

  // Neighbour select and source address for the read in flight.
  always_comb begin
    rd_x_s = sel_x0_s;
    rd_y_s = y0_r;
    case (rd_idx_r)
      N00:     begin rd_x_s = sel_x0_s; rd_y_s = y0_r; end
      N01:     begin rd_x_s = sel_x1_s; rd_y_s = y0_r; end
      N10:     begin rd_x_s = sel_x0_s; rd_y_s = y1_r; end
      N11:     begin rd_x_s = sel_x1_s; rd_y_s = y1_r; end
      default: begin rd_x_s = sel_x0_s; rd_y_s = y0_r; end
    endcase
    mem_addr = ADDR_WIDTH'(rd_y_s) * ADDR_WIDTH'(w_in_r) + ADDR_WIDTH'(rd_x_s) + BASE_ADDR;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = fetch_req ? CALC : IDLE;
      CALC:    state_nx_s = (|lv_s) ? ISSUE : DONE;
      ISSUE:   state_nx_s = last_rd_s ? DRAIN : ISSUE;
      DRAIN:   state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request latch, coordinate registers, read sequencing and pixel capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_r      <= 16'd0;
      cur_y_r      <= 16'd0;
      w_in_r       <= 16'd0;
      h_in_r       <= 16'd0;
      w_out_r      <= 16'd0;
      scale_x_r    <= 16'd0;
      scale_y_r    <= 16'd0;
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        x0_r[i] <= 16'd0;
        x1_r[i] <= 16'd0;
      end
      y0_r         <= 16'd0;
      y1_r         <= 16'd0;
      rd_lane_r    <= '0;
      rd_idx_r     <= 2'd0;
      cap_en_r     <= 1'b0;
      cap_lane_r   <= '0;
      cap_idx_r    <= 2'd0;
      pix_r        <= '0;
      frac_x_r     <= '0;
      frac_y_r     <= 8'd0;
      lane_valid_r <= '0;
    end else begin
      cap_en_r   <= (state_r == ISSUE);
      cap_lane_r <= rd_lane_r;
      cap_idx_r  <= rd_idx_r;
      case (state_r)
        IDLE: begin
          if (fetch_req) begin
            cur_x_r   <= current_x;
            cur_y_r   <= current_y;
            w_in_r    <= img_width_in;
            h_in_r    <= img_height_in;
            w_out_r   <= img_width_out;
            scale_x_r <= scale_x;
            scale_y_r <= scale_y;
          end
        end
        CALC: begin
          rd_lane_r    <= '0;
          rd_idx_r     <= 2'd0;
          y0_r         <= y0_s;
          y1_r         <= y1_s;
          frac_y_r     <= fy_s;
          lane_valid_r <= lv_s;
          pix_r        <= '0;
          for (int i = 0; i < SIMD_WIDTH; i++) begin
            x0_r[i]         <= x0_s[i];
            x1_r[i]         <= x1_s[i];
            frac_x_r[8*i+:8] <= lv_s[i] ? fx_s[i] : 8'd0;
          end
        end
        ISSUE: begin
          if (rd_idx_r == N11) begin
            rd_idx_r  <= 2'd0;
            rd_lane_r <= rd_lane_r + LANE_W'(1);
          end else begin
            rd_idx_r  <= rd_idx_r + 2'd1;
          end
        end
        default: begin
        end
      endcase
      if (cap_en_r) begin
        pix_r[{cap_lane_r, cap_idx_r, 3'b000} +: PIX_W] <= mem_rd_data;
      end
    end
  end

  assign busy       = (state_r != IDLE);
  assign fetch_done = (state_r == DONE);
  assign mem_rd_en  = (state_r == ISSUE);
  assign pix_out    = pix_r;
  assign frac_x     = frac_x_r;
  assign frac_y     = frac_y_r;
  assign lane_valid = lane_valid_r;

endmodule
